ps2_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_sync.sv | 29 ++
 rtl/ps2_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [3:0] LAST_DATA_IDX = 4'd7;
  localparam logic [3:0] PARITY_IDX    = 4'd8;
  localparam logic [3:0] STOP_IDX      = 4'd9;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge strobe.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  // NOTE: flops reset to 1 because an idle open-drain line is pulled high;
  // resetting to 0 would fake a rising edge followed by a spurious state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte with odd parity and stop bit, then collect the device ACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe_out,
  output logic       ps2_data_oe_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out
);

  import ps2_pkg::*;

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          parity;
  logic          ack_ok;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;

  ps2_sync u_clk_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .raw  (ps2_clk_in),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  ps2_sync u_data_sync (
    .clk  (clk_in),
    .rst  (rst_in),
    .raw  (ps2_data_in),
    .sync (data_sync),
    .fall (data_fall_unused)
  );

  // NOTE: all state and outputs use non-blocking assignment so every branch
  // reads the pre-edge values, exactly as the flops will in hardware.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      ps2_clk_oe_out  <= 1'b0;
      ps2_data_oe_out <= 1'b0;
      ready_out       <= 1'b1;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      inh_cnt         <= '0;
      to_cnt          <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      parity          <= 1'b0;
      ack_ok          <= 1'b0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe_out  <= 1'b0;
          ps2_data_oe_out <= 1'b0;
          if (valid_in && ready_out) begin
            shift_reg      <= data_in;
            parity         <= ~^data_in;
            inh_cnt        <= '0;
            ps2_clk_oe_out <= 1'b1;
            ready_out      <= 1'b0;
            busy_out       <= 1'b1;
            state          <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_data_oe_out <= 1'b1;
            ps2_clk_oe_out  <= 1'b0;
            to_cnt          <= '0;
            bit_idx         <= '0;
            state           <= SEND;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end

        SEND, ACK, WAIT_IDLE: begin
          // Timeout outranks any edge seen in the same cycle.
          if (to_cnt == TO_LAST) begin
            ps2_clk_oe_out  <= 1'b0;
            ps2_data_oe_out <= 1'b0;
            error_out       <= 1'b1;
            ready_out       <= 1'b1;
            busy_out        <= 1'b0;
            state           <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            case (state)
              SEND: begin
                if (clk_fall) begin
                  bit_idx <= bit_idx + 4'd1;
                  if (bit_idx <= LAST_DATA_IDX) begin
                    ps2_data_oe_out <= ~shift_reg[bit_idx[2:0]];
                  end else if (bit_idx == PARITY_IDX) begin
                    ps2_data_oe_out <= ~parity;
                  end else if (bit_idx == STOP_IDX) begin
                    ps2_data_oe_out <= 1'b0;
                    state           <= ACK;
                  end
                end
              end
              ACK: begin
                if (clk_fall) begin
                  ack_ok <= ~data_sync;
                  state  <= WAIT_IDLE;
                end
              end
              default: begin
                if (clk_sync && data_sync) begin
                  done_out  <= ack_ok;
                  error_out <= ~ack_ok;
                  ready_out <= 1'b1;
                  busy_out  <= 1'b0;
                  state     <= IDLE;
                end
              end
            endcase
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a simple PS/2 device model on open-drain lines.
module tb_ps2_tx;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       ps2_clk_oe_out;
  logic       ps2_data_oe_out;
  logic       busy_out;
  logic       done_out;
  logic       error_out;

  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clk;
  logic ps2_data;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int both_cnt    = 0;

  assign ps2_clk  = ~(ps2_clk_oe_out | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe_out | dev_data_low);

  ps2_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .ps2_clk_in      (ps2_clk),
    .ps2_data_in     (ps2_data),
    .ps2_clk_oe_out  (ps2_clk_oe_out),
    .ps2_data_oe_out (ps2_data_oe_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .error_out       (error_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (done_out)              done_cnt++;
    if (error_out)             err_cnt++;
    if (done_out && error_out) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  // Device side: measure inhibit, then clock n_falls bits, sampling on rising edges.
  task automatic dev_frame(input int n_falls, input bit do_ack,
                           output logic [10:0] bits, output int inh_len);
    bits    = '0;
    inh_len = 0;
    for (int t = 0; t < 50 && !ps2_clk_oe_out; t++) @(negedge clk_in);
    while (ps2_clk_oe_out && inh_len < 1000) begin
      inh_len++;
      @(negedge clk_in);
    end
    if (n_falls == 0) return;
    repeat (10) @(negedge clk_in);
    bits[0] = ps2_data;
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk_in);
      dev_clk_low = 1'b0;
      bits[i] = ps2_data;
      repeat (40) @(negedge clk_in);
    end
    if (n_falls == 10) begin
      if (do_ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk_in);
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk_in);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk_in);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_end();
    for (int t = 0; t < 3000 && !(done_out || error_out); t++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic run(input string tag, input logic [7:0] b, input bit do_ack,
                     input logic [10:0] exp_bits, input int exp_done);
    int d0;
    int e0;
    int inh;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    dev_frame(10, do_ack, bits, inh);
    check({tag, " inhibit_len"}, inh, 20);
    check({tag, " wire_bits"}, 32'(bits), 32'(exp_bits));
    wait_end();
    check({tag, " done_pulses"}, done_cnt - d0, exp_done);
    check({tag, " error_pulses"}, err_cnt - e0, 1 - exp_done);
    check({tag, " ready_after"}, ready_out, 1);
    check({tag, " busy_after"}, busy_out, 0);
  endtask

  initial begin
    int d0;
    int e0;
    int inh;
    logic [10:0] bits;

    rst_in       = 1'b1;
    data_in      = 8'h00;
    valid_in     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst ready", ready_out, 1);
    check("rst busy", busy_out, 0);
    check("rst clk_oe", ps2_clk_oe_out, 0);
    check("rst data_oe", ps2_data_oe_out, 0);
    check("rst done", done_out, 0);
    check("rst error", error_out, 0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // {stop, parity, data[7:0], start}
    run("F4 ack", 8'hF4, 1'b1, 11'h5E8, 1);
    run("ED ack", 8'hED, 1'b1, 11'h7DA, 1);
    run("00 nack", 8'h00, 1'b0, 11'h600, 0);

    // Device never clocks: error exactly 2000 cycles after clock release.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hF4);
    dev_frame(0, 1'b0, bits, inh);
    check("tmo inhibit_len", inh, 20);
    check("tmo start_bit_driven", ps2_data_oe_out, 1);
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk_in);
      if (n == 1999) check("tmo error_early", error_out, 0);
      if (n == 2000) begin
        check("tmo error_at_2000", error_out, 1);
        check("tmo clk_oe", ps2_clk_oe_out, 0);
        check("tmo data_oe", ps2_data_oe_out, 0);
      end
    end
    repeat (2) @(negedge clk_in);
    check("tmo done_pulses", done_cnt - d0, 0);
    check("tmo error_pulses", err_cnt - e0, 1);

    // valid_in held high with 0x11 while 0xFF is on the wire.
    d0 = done_cnt;
    e0 = err_cnt;
    data_in  = 8'hFF;
    valid_in = 1'b1;
    @(negedge clk_in);
    data_in = 8'h11;
    dev_frame(10, 1'b1, bits, inh);
    check("hold FF wire_bits", 32'(bits), 32'h7FE);
    for (int t = 0; t < 3000 && !done_out; t++) @(negedge clk_in);
    check("hold FF done", done_out, 1);
    check("hold ready_at_done", ready_out, 1);
    @(negedge clk_in);
    valid_in = 1'b0;
    check("hold 11 accepted", busy_out, 1);
    dev_frame(10, 1'b1, bits, inh);
    check("hold 11 wire_bits", 32'(bits), 32'h622);
    wait_end();
    check("hold done_pulses", done_cnt - d0, 2);
    check("hold error_pulses", err_cnt - e0, 0);

    // Asynchronous reset during bit 4 of 0xFF.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF);
    dev_frame(5, 1'b0, bits, inh);
    check("rstmid partial_bits", 32'(bits[5:0]), 32'h3E);
    check("rstmid busy_before", busy_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check("rstmid clk_oe", ps2_clk_oe_out, 0);
    check("rstmid data_oe", ps2_data_oe_out, 0);
    check("rstmid busy", busy_out, 0);
    check("rstmid ready", ready_out, 1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Asynchronous reset while the clock line is held low.
    send(8'hED);
    repeat (5) @(negedge clk_in);
    check("rstinh clk_oe_before", ps2_clk_oe_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check("rstinh clk_oe_async", ps2_clk_oe_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    check("rst done_pulses", done_cnt - d0, 0);
    check("rst error_pulses", err_cnt - e0, 0);

    run("F4 post_rst", 8'hF4, 1'b1, 11'h5E8, 1);
    check("done_and_error_same_cycle", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
